// File: rtl/prog_delay_xf_if.sv
`default_nettype none
// ============================================================================
// prog_delay_xf_if : sample/delay-control bundle for prog_delay_xf
// Revision: 1.0
// ============================================================================
interface prog_delay_xf_if #(
   parameter int W = 16,
   parameter int N = 5,
   parameter int C = 2
);
   logic             in_valid;
   logic [C*W-1:0]   a_in;
   logic [C*N-1:0]   sel;
   logic             sel_load;
   logic             out_valid;
   logic [C*W-1:0]   a_out;
   logic             busy;

   modport master (
      output in_valid, a_in, sel, sel_load,
      input  out_valid, a_out, busy
   );

   modport slave (
      input  in_valid, a_in, sel, sel_load,
      output out_valid, a_out, busy
   );
endinterface
`default_nettype wire

// File: rtl/prog_delay_xf.sv
`default_nettype none
// ============================================================================
// prog_delay_xf : multi-channel programmable sample delay, linear crossfade on change
// Revision: 1.0
// ============================================================================
module prog_delay_xf #(
   parameter int W = 16,
   parameter int N = 5,
   parameter int L = 32,
   parameter int C = 2,
   parameter int K = 3
) (
   input  logic           clk,
   input  logic           rst,
   prog_delay_xf_if.slave bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFADE = 1'b1} state_t;

   localparam logic [N-1:0] D_MAX = N'(L - 1);
   localparam logic [K:0]   K_END = {1'b1, {K{1'b0}}};

   state_t                state_q, state_d;
   logic signed [W-1:0]   tap_q [C][L];
   logic signed [W-1:0]   tap_d [C][L];
   logic signed [W-1:0]   post  [C][L];
   logic [N-1:0]          cur_dly_q  [C];
   logic [N-1:0]          cur_dly_d  [C];
   logic [N-1:0]          new_dly_q  [C];
   logic [N-1:0]          new_dly_d  [C];
   logic [N-1:0]          pend_dly_q [C];
   logic [N-1:0]          pend_dly_d [C];
   logic                  pend_q, pend_d;
   logic [K:0]            k_q, k_d;
   logic [C*W-1:0]        a_out_q, a_out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;

   logic [N-1:0]          sel_clamp [C];
   logic [N-1:0]          tgt_dly   [C];
   logic [K:0]            k_use, k_nxt;
   logic                  any_diff;
   logic signed [W-1:0]   o_smp [C];
   logic signed [W-1:0]   n_smp [C];
   logic signed [W:0]     diff  [C];
   logic signed [W+K+1:0] prod  [C];

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      k_d         = k_q;
      a_out_d     = a_out_q;
      out_valid_d = bus.in_valid;
      busy_d      = pend_q | (state_q == ST_XFADE);
      k_use       = '0;
      k_nxt       = k_q + (K+1)'(1);
      any_diff    = 1'b0;

      for (int c = 0; c < C; c++) begin
         tap_d[c]      = tap_q[c];
         cur_dly_d[c]  = cur_dly_q[c];
         new_dly_d[c]  = new_dly_q[c];
         pend_dly_d[c] = pend_dly_q[c];
         tgt_dly[c]    = cur_dly_q[c];
         sel_clamp[c]  = (bus.sel[c*N +: N] > D_MAX) ? D_MAX : bus.sel[c*N +: N];
         any_diff      = any_diff | (pend_dly_q[c] != cur_dly_q[c]);
         // Line contents as they will be after this cycle's shift; tap 0 is the live input.
         post[c][0]    = bus.a_in[c*W +: W];
         for (int i = 1; i < L; i++) begin
            post[c][i] = tap_q[c][i-1];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && pend_q) begin
               pend_d = 1'b0;
               if (any_diff) begin
                  for (int c = 0; c < C; c++) begin
                     new_dly_d[c] = pend_dly_q[c];
                     tgt_dly[c]   = pend_dly_q[c];
                  end
                  k_use   = (K+1)'(1);
                  k_d     = (K+1)'(1);
                  state_d = ST_XFADE;
               end
            end
         end
         ST_XFADE: begin
            for (int c = 0; c < C; c++) begin
               tgt_dly[c] = new_dly_q[c];
            end
            // k_q holds the weight of the last faded sample, so this sample uses k_q+1.
            if (bus.in_valid) begin
               k_use = k_nxt;
               if (k_nxt == K_END) begin
                  for (int c = 0; c < C; c++) begin
                     cur_dly_d[c] = new_dly_q[c];
                  end
                  k_d     = '0;
                  state_d = ST_IDLE;
               end else begin
                  k_d = k_nxt;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.sel_load) begin
         pend_d = 1'b1;
         for (int c = 0; c < C; c++) begin
            pend_dly_d[c] = sel_clamp[c];
         end
      end

      for (int c = 0; c < C; c++) begin
         o_smp[c] = post[c][cur_dly_q[c]];
         n_smp[c] = post[c][tgt_dly[c]];
         diff[c]  = {n_smp[c][W-1], n_smp[c]} - {o_smp[c][W-1], o_smp[c]};
         prod[c]  = (W+K+2)'(diff[c]) * $signed((W+K+2)'({1'b0, k_use}));
         if (bus.in_valid) begin
            tap_d[c]            = post[c];
            a_out_d[c*W +: W]   = o_smp[c] + W'(prod[c] >>> K);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pend_q      <= 1'b0;
         k_q         <= '0;
         a_out_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int c = 0; c < C; c++) begin
            cur_dly_q[c]  <= '0;
            new_dly_q[c]  <= '0;
            pend_dly_q[c] <= '0;
            for (int i = 0; i < L; i++) begin
               tap_q[c][i] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         k_q         <= k_d;
         a_out_q     <= a_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         cur_dly_q   <= cur_dly_d;
         new_dly_q   <= new_dly_d;
         pend_dly_q  <= pend_dly_d;
         tap_q       <= tap_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.a_out     = a_out_q;
   assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_delay_xf.sv
`default_nettype none
// ============================================================================
// tb_prog_delay_xf : directed scoreboard bench for prog_delay_xf (L=24 for clamping)
// Revision: 1.0
// ============================================================================
module tb_prog_delay_xf;
   localparam int W = 16;
   localparam int N = 5;
   localparam int L = 24;
   localparam int C = 2;
   localparam int K = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_delay_xf_if #(.W(W), .N(N), .C(C)) bus ();

   prog_delay_xf #(.W(W), .N(N), .L(L), .C(C), .K(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [C*W-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got %h expected no output", bus.a_out);
         end else begin
            check("a_out", bus.a_out, exp_q.pop_front());
         end
      end
   end

   task automatic send(input int v0, input int v1, input int e0, input int e1);
      bus.in_valid = 1'b1;
      bus.a_in     = {W'(v1), W'(v0)};
      exp_q.push_back({W'(e1), W'(e0)});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic load(input int s0, input int s1);
      bus.sel      = {N'(s1), N'(s0)};
      bus.sel_load = 1'b1;
      @(posedge clk); #1;
      bus.sel_load = 1'b0;
   endtask

   task automatic load_send(input int s0, input int s1, input int v0, input int v1,
                            input int e0, input int e1);
      bus.sel      = {N'(s1), N'(s0)};
      bus.sel_load = 1'b1;
      send(v0, v1, e0, e1);
      bus.sel_load = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Settle channel 0 (and optionally channel 1) on delay 20 over an all-zero history.
   task automatic prime(input int s1);
      load(20, s1);
      repeat (8) send(0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int e0t [6] = '{0, 0, 0, 1, 2, 3};
      int nfl [8] = '{-1, -2, -3, -4, -5, -6, -7, -7};
      int pfl [8] = '{0, 1, 2, 3, 4, 5, 6, 7};

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a_in     = '0;
      bus.sel      = '0;
      bus.sel_load = 1'b0;
      idle(2);
      do_reset();
      check("rst_a_out",     32'(bus.a_out),     32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);

      // Pass-through at d=0
      send(100, -5, 100, -5);
      send(200,  7, 200,  7);
      send(300,  0, 300,  0);
      idle(1);

      // Fixed delays ch0=3, ch1=1
      do_reset();
      load(3, 1);
      send(0, 0, 0, 0);
      check("busy_after_load", 32'(bus.busy), 32'd1);
      repeat (7) send(0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) send(i, 10 * i, e0t[i-1], 10 * (i - 1));
      check("busy_fixed_idle", 32'(bus.busy), 32'd0);

      // Clamp: 31 requested, line is 24 deep -> delay 23
      do_reset();
      load(31, 0);
      repeat (8) send(0, 0, 0, 0);
      for (int j = 1; j <= 25; j++) send(j, j, (j >= 24) ? j - 23 : 0, j);

      // Crossfade from zero history to 800, ch1 unchanged
      do_reset();
      prime(0);
      load(0, 0);
      for (int k = 1; k <= 8; k++) begin
         send(800, 5, 100 * k, 5);
         if (k == 1 || k == 4) check("busy_xfade", 32'(bus.busy), 32'd1);
      end
      idle(2);
      check("busy_after_xfade", 32'(bus.busy), 32'd0);

      // Floor rounding toward -inf on ch0, positive ramp on ch1
      do_reset();
      prime(20);
      load(0, 0);
      for (int k = 0; k < 8; k++) send(-7, 7, nfl[k], pfl[k]);
      idle(1);

      // Load mid-crossfade with gaps
      do_reset();
      prime(0);
      load(0, 0);
      send(800, 0, 100, 0);
      send(800, 0, 200, 0);
      idle(3);
      send(800, 0, 300, 0);
      load_send(2, 0, 800, 0, 400, 0);
      idle(1);
      send(800, 0, 500, 0);
      idle(2);
      send(800, 0, 600, 0);
      send(800, 0, 700, 0);
      send(800, 0, 800, 0);
      idle(2);
      check("busy_pend_held", 32'(bus.busy), 32'd1);
      send(0, 0, 100, 0);
      send(0, 0, 200, 0);
      repeat (6) send(0, 0, 0, 0);
      idle(2);
      check("busy_second_done", 32'(bus.busy), 32'd0);
      send(11, 0, 0, 0);
      send(22, 0, 0, 0);
      send(33, 0, 11, 0);

      // Reset at k=5, with a sample and a load presented during reset
      do_reset();
      prime(0);
      load(0, 0);
      for (int k = 1; k <= 5; k++) send(800, 7, 100 * k, 7);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a_in     = {W'(999), W'(999)};
      bus.sel      = {N'(5), N'(5)};
      bus.sel_load = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.sel_load = 1'b0;
      check("midrst_a_out",     32'(bus.a_out),     32'd0);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy",      32'(bus.busy),      32'd0);
      send(55, 66, 55, 66);
      send(77, -3, 77, -3);
      idle(1);
      check("midrst_busy_after", 32'(bus.busy), 32'd0);

      for (int t = 0; t < 10; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
